// File: rtl/tic_tac_toe_turn_scheduler.sv
// ============================================================================
// Module   : tic_tac_toe_turn_scheduler
// Brief    : Sequences player/computer moves into the board registers,
//            validates occupancy, detects game end and per-turn timeouts.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tic_tac_toe_turn_scheduler #(
    parameter int TURN_TIMEOUT = 1024
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       pl_req,
    input  logic [3:0] pl_pos,
    input  logic       pc_req,
    input  logic [3:0] pc_pos,
    input  logic [8:0] occupied,
    input  logic       win,
    input  logic       no_space,
    output logic       clear_board,
    output logic       wr_en,
    output logic [3:0] wr_pos,
    output logic [1:0] wr_who,
    output logic       ack,
    output logic       nack,
    output logic [1:0] turn,
    output logic [3:0] move_count,
    output logic       game_over,
    output logic [1:0] result,
    output logic       forfeit
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_PL_TURN = 3'd2,
        ST_CO_TURN = 3'd3,
        ST_WRITE   = 3'd4,
        ST_CHECK   = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    localparam logic [1:0]  c_WHO_NONE = 2'b00;
    localparam logic [1:0]  c_WHO_PL   = 2'b01;
    localparam logic [1:0]  c_WHO_CO   = 2'b10;
    localparam logic [1:0]  c_DRAW     = 2'b11;
    localparam logic [15:0] c_TMO_LAST = 16'(TURN_TIMEOUT - 1);

    state_t      r_state;
    logic        r_starter_co;
    logic [15:0] r_tmo_cnt;
    logic        r_clear_board;
    logic        r_wr_en;
    logic [3:0]  r_wr_pos;
    logic [1:0]  r_wr_who;
    logic        r_ack;
    logic        r_nack;
    logic [1:0]  r_turn;
    logic [3:0]  r_move_count;
    logic        r_game_over;
    logic [1:0]  r_result;
    logic        r_forfeit;

    state_t      w_state_nxt;
    logic        w_starter_co_nxt;
    logic [15:0] w_tmo_cnt_nxt;
    logic        w_clear_board_nxt;
    logic        w_wr_en_nxt;
    logic [3:0]  w_wr_pos_nxt;
    logic [1:0]  w_wr_who_nxt;
    logic        w_ack_nxt;
    logic        w_nack_nxt;
    logic [1:0]  w_turn_nxt;
    logic [3:0]  w_move_count_nxt;
    logic        w_game_over_nxt;
    logic [1:0]  w_result_nxt;
    logic        w_forfeit_nxt;

    logic        w_req;
    logic [3:0]  w_pos;
    logic [1:0]  w_side;
    logic [1:0]  w_other;
    logic        w_pos_ok;

    // Only the side holding the turn is ever looked at.
    always_comb begin
        w_req   = 1'b0;
        w_pos   = 4'd0;
        w_side  = c_WHO_PL;
        w_other = c_WHO_CO;
        if (r_state == ST_PL_TURN) begin
            w_req = pl_req;
            w_pos = pl_pos;
        end else if (r_state == ST_CO_TURN) begin
            w_req   = pc_req;
            w_pos   = pc_pos;
            w_side  = c_WHO_CO;
            w_other = c_WHO_PL;
        end
        w_pos_ok = (w_pos <= 4'd8) && !occupied[w_pos];
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_starter_co_nxt  = r_starter_co;
        w_tmo_cnt_nxt     = r_tmo_cnt;
        w_clear_board_nxt = 1'b0;
        w_wr_en_nxt       = 1'b0;
        w_wr_pos_nxt      = r_wr_pos;
        w_wr_who_nxt      = r_wr_who;
        w_ack_nxt         = 1'b0;
        w_nack_nxt        = 1'b0;
        w_turn_nxt        = r_turn;
        w_move_count_nxt  = r_move_count;
        w_game_over_nxt   = r_game_over;
        w_result_nxt      = r_result;
        w_forfeit_nxt     = r_forfeit;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt       = ST_CLEAR;
                    w_clear_board_nxt = 1'b1;
                    w_move_count_nxt  = 4'd0;
                    w_game_over_nxt   = 1'b0;
                    w_result_nxt      = c_WHO_NONE;
                    w_forfeit_nxt     = 1'b0;
                    // Alternate the first mover only between consecutive games.
                    if (r_state == ST_DONE) begin
                        w_starter_co_nxt = ~r_starter_co;
                    end
                end
            end
            ST_CLEAR: begin
                w_tmo_cnt_nxt = 16'd0;
                if (r_starter_co) begin
                    w_state_nxt = ST_CO_TURN;
                    w_turn_nxt  = c_WHO_CO;
                end else begin
                    w_state_nxt = ST_PL_TURN;
                    w_turn_nxt  = c_WHO_PL;
                end
            end
            ST_PL_TURN, ST_CO_TURN: begin
                w_tmo_cnt_nxt = r_tmo_cnt + 16'd1;
                if (w_req && w_pos_ok) begin
                    w_state_nxt      = ST_WRITE;
                    w_wr_en_nxt      = 1'b1;
                    w_ack_nxt        = 1'b1;
                    w_wr_pos_nxt     = w_pos;
                    w_wr_who_nxt     = w_side;
                    w_move_count_nxt = r_move_count + 4'd1;
                    w_turn_nxt       = c_WHO_NONE;
                end else begin
                    w_nack_nxt = w_req;
                    if (r_tmo_cnt == c_TMO_LAST) begin
                        w_state_nxt     = ST_DONE;
                        w_turn_nxt      = c_WHO_NONE;
                        w_game_over_nxt = 1'b1;
                        w_forfeit_nxt   = 1'b1;
                        w_result_nxt    = w_other;
                    end
                end
            end
            ST_WRITE: begin
                w_state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                // Board has absorbed the write; a completed line beats a full board.
                if (win) begin
                    w_state_nxt     = ST_DONE;
                    w_game_over_nxt = 1'b1;
                    w_result_nxt    = r_wr_who;
                end else if (no_space) begin
                    w_state_nxt     = ST_DONE;
                    w_game_over_nxt = 1'b1;
                    w_result_nxt    = c_DRAW;
                end else begin
                    w_tmo_cnt_nxt = 16'd0;
                    if (r_wr_who == c_WHO_PL) begin
                        w_state_nxt = ST_CO_TURN;
                        w_turn_nxt  = c_WHO_CO;
                    end else begin
                        w_state_nxt = ST_PL_TURN;
                        w_turn_nxt  = c_WHO_PL;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_turn_nxt  = c_WHO_NONE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_starter_co  <= 1'b0;
            r_tmo_cnt     <= 16'd0;
            r_clear_board <= 1'b0;
            r_wr_en       <= 1'b0;
            r_wr_pos      <= 4'd0;
            r_wr_who      <= c_WHO_NONE;
            r_ack         <= 1'b0;
            r_nack        <= 1'b0;
            r_turn        <= c_WHO_NONE;
            r_move_count  <= 4'd0;
            r_game_over   <= 1'b0;
            r_result      <= c_WHO_NONE;
            r_forfeit     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_starter_co  <= w_starter_co_nxt;
            r_tmo_cnt     <= w_tmo_cnt_nxt;
            r_clear_board <= w_clear_board_nxt;
            r_wr_en       <= w_wr_en_nxt;
            r_wr_pos      <= w_wr_pos_nxt;
            r_wr_who      <= w_wr_who_nxt;
            r_ack         <= w_ack_nxt;
            r_nack        <= w_nack_nxt;
            r_turn        <= w_turn_nxt;
            r_move_count  <= w_move_count_nxt;
            r_game_over   <= w_game_over_nxt;
            r_result      <= w_result_nxt;
            r_forfeit     <= w_forfeit_nxt;
        end
    end

    assign clear_board = r_clear_board;
    assign wr_en       = r_wr_en;
    assign wr_pos      = r_wr_pos;
    assign wr_who      = r_wr_who;
    assign ack         = r_ack;
    assign nack        = r_nack;
    assign turn        = r_turn;
    assign move_count  = r_move_count;
    assign game_over   = r_game_over;
    assign result      = r_result;
    assign forfeit     = r_forfeit;

endmodule

`default_nettype wire

// File: tb/tb_tic_tac_toe_turn_scheduler.sv
// ============================================================================
// Module   : tb_tic_tac_toe_turn_scheduler
// Brief    : Directed self-checking bench for the turn scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tic_tac_toe_turn_scheduler;

    logic       clock    = 1'b0;
    logic       reset    = 1'b1;
    logic       start    = 1'b0;
    logic       pl_req   = 1'b0;
    logic [3:0] pl_pos   = 4'd0;
    logic       pc_req   = 1'b0;
    logic [3:0] pc_pos   = 4'd0;
    logic [8:0] occ;
    logic       win      = 1'b0;
    logic       no_space = 1'b0;

    logic       clear_board;
    logic       wr_en;
    logic [3:0] wr_pos;
    logic [1:0] wr_who;
    logic       ack;
    logic       nack;
    logic [1:0] turn;
    logic [3:0] move_count;
    logic       game_over;
    logic [1:0] result;
    logic       forfeit;
    logic [19:0] all_out;

    int n_tests = 0;
    int n_fail  = 0;

    tic_tac_toe_turn_scheduler #(.TURN_TIMEOUT(8)) u_dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .pl_req      (pl_req),
        .pl_pos      (pl_pos),
        .pc_req      (pc_req),
        .pc_pos      (pc_pos),
        .occupied    (occ),
        .win         (win),
        .no_space    (no_space),
        .clear_board (clear_board),
        .wr_en       (wr_en),
        .wr_pos      (wr_pos),
        .wr_who      (wr_who),
        .ack         (ack),
        .nack        (nack),
        .turn        (turn),
        .move_count  (move_count),
        .game_over   (game_over),
        .result      (result),
        .forfeit     (forfeit)
    );

    assign all_out = {clear_board, wr_en, wr_pos, wr_who, ack, nack, turn,
                      move_count, game_over, result, forfeit};

    always #5 clock = ~clock;

    // Stand-in for the board position registers.
    always @(posedge clock or posedge reset) begin
        if (reset)            occ <= 9'd0;
        else if (clear_board) occ <= 9'd0;
        else if (wr_en)       occ[wr_pos] <= 1'b1;
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        tick();
    endtask

    task automatic start_game;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic move(input logic side_pc, input logic [3:0] pos,
                        input logic w, input logic ns);
        if (side_pc) begin pc_req = 1'b1; pc_pos = pos; end
        else         begin pl_req = 1'b1; pl_pos = pos; end
        tick();
        pl_req   = 1'b0;
        pc_req   = 1'b0;
        win      = w;
        no_space = ns;
        tick();
        tick();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        n_tests++;
        if (all_out !== 20'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want %h", all_out, 20'd0);
        end
        reset = 1'b0;
        tick();
        tick();
        n_tests++;
        if (all_out !== 20'd0) begin
            n_fail++; $display("FAIL idle_no_start: got %h want %h", all_out, 20'd0);
        end
    endtask

    task automatic test_first_move;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_tests++;
        if ({clear_board, turn} !== 3'b1_00) begin
            n_fail++; $display("FAIL start_clear: got %b want %b", {clear_board, turn}, 3'b1_00);
        end
        tick();
        n_tests++;
        if ({clear_board, turn} !== 3'b0_01) begin
            n_fail++; $display("FAIL first_turn: got %b want %b", {clear_board, turn}, 3'b0_01);
        end
        pl_req = 1'b1; pl_pos = 4'd4;
        tick();
        pl_req = 1'b0;
        n_tests++;
        if ({wr_en, ack, wr_pos, wr_who, turn, move_count} !== 14'b1_1_0100_01_00_0001) begin
            n_fail++; $display("FAIL pl_write: got %b want %b",
                {wr_en, ack, wr_pos, wr_who, turn, move_count}, 14'b1_1_0100_01_00_0001);
        end
        tick();
        n_tests++;
        if ({wr_en, ack, turn} !== 4'b0_0_00) begin
            n_fail++; $display("FAIL check_cycle: got %b want %b", {wr_en, ack, turn}, 4'b0_0_00);
        end
        tick();
        n_tests++;
        if ({turn, move_count} !== 6'b10_0001) begin
            n_fail++; $display("FAIL co_turn_after: got %b want %b", {turn, move_count}, 6'b10_0001);
        end
    endtask

    task automatic test_nack;
        pc_req = 1'b1; pc_pos = 4'd4;
        tick();
        n_tests++;
        if ({nack, wr_en, ack, turn} !== 5'b1_0_0_10) begin
            n_fail++; $display("FAIL nack_occupied: got %b want %b", {nack, wr_en, ack, turn}, 5'b1_0_0_10);
        end
        tick();
        n_tests++;
        if ({nack, wr_en} !== 2'b1_0) begin
            n_fail++; $display("FAIL nack_held: got %b want %b", {nack, wr_en}, 2'b1_0);
        end
        pc_pos = 4'd9;
        tick();
        n_tests++;
        if ({nack, wr_en, turn} !== 4'b1_0_10) begin
            n_fail++; $display("FAIL nack_pos9: got %b want %b", {nack, wr_en, turn}, 4'b1_0_10);
        end
        pc_pos = 4'd0;
        tick();
        pc_req = 1'b0;
        n_tests++;
        if ({ack, nack, wr_en, wr_pos, wr_who} !== 9'b1_0_1_0000_10) begin
            n_fail++; $display("FAIL co_write: got %b want %b", {ack, nack, wr_en, wr_pos, wr_who}, 9'b1_0_1_0000_10);
        end
        tick();
        tick();
        n_tests++;
        if ({turn, move_count} !== 6'b01_0010) begin
            n_fail++; $display("FAIL pl_turn_back: got %b want %b", {turn, move_count}, 6'b01_0010);
        end
    endtask

    task automatic test_ignored;
        pc_req = 1'b1; pc_pos = 4'd5; start = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({nack, wr_en, ack, clear_board, turn, move_count} !== 10'b0_0_0_0_01_0010) begin
            n_fail++; $display("FAIL ignore_pc_start: got %b want %b",
                {nack, wr_en, ack, clear_board, turn, move_count}, 10'b0_0_0_0_01_0010);
        end
        pc_req = 1'b0; start = 1'b0;
    endtask

    task automatic test_win;
        do_reset();
        start_game();
        move(1'b0, 4'd0, 1'b0, 1'b0);
        move(1'b1, 4'd3, 1'b0, 1'b0);
        move(1'b0, 4'd1, 1'b0, 1'b0);
        move(1'b1, 4'd4, 1'b0, 1'b0);
        // Winning line and full board reported together: line wins.
        move(1'b0, 4'd2, 1'b1, 1'b1);
        n_tests++;
        if ({game_over, result, forfeit, move_count, turn} !== 10'b1_01_0_0101_00) begin
            n_fail++; $display("FAIL win_result: got %b want %b",
                {game_over, result, forfeit, move_count, turn}, 10'b1_01_0_0101_00);
        end
        pl_req = 1'b1; pl_pos = 4'd5;
        tick();
        tick();
        pl_req = 1'b0;
        n_tests++;
        if ({wr_en, ack, nack, game_over, move_count} !== 8'b0_0_0_1_0101) begin
            n_fail++; $display("FAIL done_ignores: got %b want %b",
                {wr_en, ack, nack, game_over, move_count}, 8'b0_0_0_1_0101);
        end
        win = 1'b0; no_space = 1'b0;
    endtask

    task automatic test_draw;
        logic [3:0] seq [9];
        seq = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd3, 4'd5, 4'd7, 4'd6, 4'd8};
        do_reset();
        start_game();
        for (int i = 0; i < 8; i++) move(i[0], seq[i], 1'b0, 1'b0);
        n_tests++;
        if ({turn, move_count, game_over} !== 7'b01_1000_0) begin
            n_fail++; $display("FAIL draw_eight: got %b want %b", {turn, move_count, game_over}, 7'b01_1000_0);
        end
        move(1'b0, seq[8], 1'b0, 1'b1);
        n_tests++;
        if ({game_over, result, forfeit, move_count} !== 8'b1_11_0_1001) begin
            n_fail++; $display("FAIL draw_result: got %b want %b",
                {game_over, result, forfeit, move_count}, 8'b1_11_0_1001);
        end
        no_space = 1'b0;
    endtask

    task automatic test_timeout;
        int cnt;
        do_reset();
        start_game();
        move(1'b0, 4'd0, 1'b0, 1'b0);
        cnt = 0;
        while (turn === 2'b10 && cnt < 20) begin
            cnt++;
            tick();
        end
        n_tests++;
        if (cnt != 8) begin
            n_fail++; $display("FAIL co_timeout_cycles: got %0d want %0d", cnt, 8);
        end
        n_tests++;
        if ({game_over, forfeit, result, turn} !== 6'b1_1_01_00) begin
            n_fail++; $display("FAIL co_forfeit: got %b want %b", {game_over, forfeit, result, turn}, 6'b1_1_01_00);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_tests++;
        if ({clear_board, game_over, forfeit, result, move_count} !== 9'b1_0_0_00_0000) begin
            n_fail++; $display("FAIL restart_clear: got %b want %b",
                {clear_board, game_over, forfeit, result, move_count}, 9'b1_0_0_00_0000);
        end
        tick();
        n_tests++;
        if (turn !== 2'b10) begin
            n_fail++; $display("FAIL starter_toggle: got %b want %b", turn, 2'b10);
        end
    endtask

    task automatic test_timeout_boundary;
        repeat (7) tick();
        n_tests++;
        if ({turn, game_over} !== 3'b10_0) begin
            n_fail++; $display("FAIL no_early_timeout: got %b want %b", {turn, game_over}, 3'b10_0);
        end
        pc_req = 1'b1; pc_pos = 4'd4;
        tick();
        pc_req = 1'b0;
        n_tests++;
        if ({ack, wr_en, forfeit, game_over} !== 4'b1_1_0_0) begin
            n_fail++; $display("FAIL last_cycle_move: got %b want %b", {ack, wr_en, forfeit, game_over}, 4'b1_1_0_0);
        end
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if (all_out !== 20'd0) begin
            n_fail++; $display("FAIL reset_in_write: got %h want %h", all_out, 20'd0);
        end
        do_reset();
    endtask

    task automatic test_reset_check;
        int cnt;
        n_tests++;
        if (all_out !== 20'd0) begin
            n_fail++; $display("FAIL idle_after_reset: got %h want %h", all_out, 20'd0);
        end
        start_game();
        n_tests++;
        if (turn !== 2'b01) begin
            n_fail++; $display("FAIL starter_reset: got %b want %b", turn, 2'b01);
        end
        pl_req = 1'b1; pl_pos = 4'd1;
        tick();
        pl_req = 1'b0;
        tick();
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if (all_out !== 20'd0) begin
            n_fail++; $display("FAIL reset_in_check: got %h want %h", all_out, 20'd0);
        end
        do_reset();
        start_game();
        cnt = 0;
        while (turn === 2'b01 && cnt < 20) begin
            cnt++;
            tick();
        end
        n_tests++;
        if (cnt != 8) begin
            n_fail++; $display("FAIL pl_timeout_cycles: got %0d want %0d", cnt, 8);
        end
        n_tests++;
        if ({game_over, forfeit, result, move_count} !== 8'b1_1_10_0000) begin
            n_fail++; $display("FAIL pl_forfeit: got %b want %b",
                {game_over, forfeit, result, move_count}, 8'b1_1_10_0000);
        end
    endtask

    initial begin
        test_reset();
        test_first_move();
        test_nack();
        test_ignored();
        test_win();
        test_draw();
        test_timeout();
        test_timeout_boundary();
        test_reset_check();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1);
    end

endmodule

`default_nettype wire
